// File: rtl/sram_bus_arbiter_pkg.sv
// Shared IDs, size encodings and request payload layout for the SRAM-like bus arbiter.
package sram_bus_arbiter_pkg;

  localparam logic MASTER_INST = 1'b0;
  localparam logic MASTER_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned SRAM_REQ_WIDTH = 71;

  // Request payload without the req strobe itself.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response bundle; master drives the request, slave answers.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wstrb, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wstrb, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_bus_arbiter_id_fifo.sv
// In-order 1-bit ID FIFO recording which master owns each accepted request.
module sram_bus_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             din_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the inst and data SRAM-like masters onto one slave port and
// routes in-order responses back to their owners.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_MAX      = 8,
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING) + 1,
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  sram_bus_arbiter_if.slave   inst_bus,
  sram_bus_arbiter_if.slave   data_bus,
  sram_bus_arbiter_if.master  mem_bus,
  output logic [CNT_W-1:0]    outstanding,
  output logic                err_unexpected
);

  logic                lock_valid_q, lock_valid_d;
  logic                lock_id_q, lock_id_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                err_q, err_d;

  logic      grant_valid, grant_id, granted_req;
  logic      issue, accept, resp_ok;
  logic      fifo_head, fifo_full, fifo_empty;
  sram_req_t inst_pl, data_pl, grant_pl;

  assign inst_pl = {inst_bus.wr, inst_bus.size, inst_bus.addr, inst_bus.wstrb, inst_bus.wdata};
  assign data_pl = {data_bus.wr, data_bus.size, data_bus.addr, data_bus.wstrb, data_bus.wdata};

  // A pending (rejected) request keeps the bus until accepted; otherwise data
  // wins unless inst has waited through STARVE_MAX data grants.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = MASTER_INST;
    if (lock_valid_q) begin
      grant_valid = 1'b1;
      grant_id    = lock_id_q;
    end else if (data_bus.req &&
                 !(inst_bus.req && (starve_cnt_q == STARVE_W'(STARVE_MAX)))) begin
      grant_valid = 1'b1;
      grant_id    = MASTER_DATA;
    end else if (inst_bus.req) begin
      grant_valid = 1'b1;
      grant_id    = MASTER_INST;
    end
  end

  assign granted_req = grant_valid & ((grant_id == MASTER_DATA) ? data_bus.req : inst_bus.req);
  assign issue       = granted_req & ~fifo_full;
  assign accept      = issue & mem_bus.addr_ok;
  assign resp_ok     = mem_bus.data_ok & ~fifo_empty;

  always_comb begin
    grant_pl = '0;
    if (grant_valid) begin
      grant_pl = (grant_id == MASTER_DATA) ? data_pl : inst_pl;
    end
  end

  assign mem_bus.req   = issue;
  assign mem_bus.wr    = grant_pl.wr;
  assign mem_bus.size  = grant_pl.size;
  assign mem_bus.addr  = grant_pl.addr;
  assign mem_bus.wstrb = grant_pl.wstrb;
  assign mem_bus.wdata = grant_pl.wdata;

  assign inst_bus.addr_ok = accept & (grant_id == MASTER_INST);
  assign data_bus.addr_ok = accept & (grant_id == MASTER_DATA);
  assign inst_bus.data_ok = resp_ok & (fifo_head == MASTER_INST);
  assign data_bus.data_ok = resp_ok & (fifo_head == MASTER_DATA);
  assign inst_bus.rdata   = mem_bus.rdata;
  assign data_bus.rdata   = mem_bus.rdata;

  assign err_unexpected = err_q;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q | (mem_bus.data_ok & fifo_empty);

    if (accept) begin
      lock_valid_d = 1'b0;
    end else if (issue) begin
      lock_valid_d = 1'b1;
      lock_id_d    = grant_id;
    end

    if (!inst_bus.req) begin
      starve_cnt_d = '0;
    end else if (accept && (grant_id == MASTER_INST)) begin
      starve_cnt_d = '0;
    end else if (accept && (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  sram_bus_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .din_i   (grant_id),
    .pop_i   (resp_ok),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench: directed scenarios plus a queue-based random reference model.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  localparam int MAXO = 4;
  localparam int SMAX = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] outstanding;
  logic       err_unexpected;
  int         tests = 0;
  int         fails = 0;

  sram_bus_arbiter_if inst_if ();
  sram_bus_arbiter_if data_if ();
  sram_bus_arbiter_if mem_if ();

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_MAX(SMAX)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_bus       (inst_if),
    .data_bus       (data_if),
    .mem_bus        (mem_if),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = SIZE_WORD; inst_if.addr = 0;
    inst_if.wstrb = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = SIZE_WORD; data_if.addr = 0;
    data_if.wstrb = 0; data_if.wdata = 0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;
  endtask

  // Hold reset over one rising edge; returns at a falling edge with inputs idle.
  task automatic apply_reset();
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    tests++; if (err_unexpected !== 1'b0) begin fails++; $display("FAIL reset_err got=%0b exp=0", err_unexpected); end
    tests++; if (mem_if.req !== 1'b0) begin fails++; $display("FAIL reset_req got=%0b exp=0", mem_if.req); end
    tests++; if (mem_if.addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", mem_if.addr); end
    tests++; if (inst_if.addr_ok !== 1'b0) begin fails++; $display("FAIL reset_inst_addr_ok got=%0b exp=0", inst_if.addr_ok); end
    tests++; if (data_if.data_ok !== 1'b0) begin fails++; $display("FAIL reset_data_data_ok got=%0b exp=0", data_if.data_ok); end
  endtask

  task automatic test_inst_only();
    apply_reset();
    inst_if.req = 1; inst_if.addr = 32'h1c000000; mem_if.addr_ok = 1;
    #1;
    tests++; if (mem_if.req !== 1'b1) begin fails++; $display("FAIL inst_only_req got=%0b exp=1", mem_if.req); end
    tests++; if (mem_if.addr !== 32'h1c000000) begin fails++; $display("FAIL inst_only_addr got=%h exp=1c000000", mem_if.addr); end
    tests++; if (inst_if.addr_ok !== 1'b1) begin fails++; $display("FAIL inst_only_addr_ok got=%0b exp=1", inst_if.addr_ok); end
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL inst_only_out0 got=%0d exp=0", outstanding); end
    @(negedge clk);
    inst_if.req = 0; mem_if.addr_ok = 0;
    #1;
    tests++; if (outstanding !== 3'd1) begin fails++; $display("FAIL inst_only_out1 got=%0d exp=1", outstanding); end
    tests++; if (data_if.data_ok !== 1'b0) begin fails++; $display("FAIL inst_only_ddok1 got=%0b exp=0", data_if.data_ok); end
    @(negedge clk);
    mem_if.data_ok = 1; mem_if.rdata = 32'h02800c0c;
    #1;
    tests++; if (inst_if.data_ok !== 1'b1) begin fails++; $display("FAIL inst_only_idok got=%0b exp=1", inst_if.data_ok); end
    tests++; if (inst_if.rdata !== 32'h02800c0c) begin fails++; $display("FAIL inst_only_rdata got=%h exp=02800c0c", inst_if.rdata); end
    tests++; if (data_if.data_ok !== 1'b0) begin fails++; $display("FAIL inst_only_ddok2 got=%0b exp=0", data_if.data_ok); end
    tests++; if (outstanding !== 3'd1) begin fails++; $display("FAIL inst_only_out2 got=%0d exp=1", outstanding); end
    @(negedge clk);
    mem_if.data_ok = 0;
    #1;
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL inst_only_out3 got=%0d exp=0", outstanding); end
  endtask

  task automatic test_priority();
    apply_reset();
    inst_if.req = 1; inst_if.addr = 32'h1c000100;
    data_if.req = 1; data_if.addr = 32'h80000040; data_if.wr = 1; data_if.wdata = 32'hcafef00d;
    data_if.wstrb = 4'hf; mem_if.addr_ok = 1;
    #1;
    tests++; if (mem_if.addr !== 32'h80000040) begin fails++; $display("FAIL prio_addr_d got=%h exp=80000040", mem_if.addr); end
    tests++; if (mem_if.wdata !== 32'hcafef00d) begin fails++; $display("FAIL prio_wdata got=%h exp=cafef00d", mem_if.wdata); end
    tests++; if (data_if.addr_ok !== 1'b1) begin fails++; $display("FAIL prio_daok got=%0b exp=1", data_if.addr_ok); end
    tests++; if (inst_if.addr_ok !== 1'b0) begin fails++; $display("FAIL prio_iaok0 got=%0b exp=0", inst_if.addr_ok); end
    @(negedge clk);
    data_if.req = 0;
    #1;
    tests++; if (mem_if.addr !== 32'h1c000100) begin fails++; $display("FAIL prio_addr_i got=%h exp=1c000100", mem_if.addr); end
    tests++; if (inst_if.addr_ok !== 1'b1) begin fails++; $display("FAIL prio_iaok1 got=%0b exp=1", inst_if.addr_ok); end
    @(negedge clk);
    inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h11111111;
    #1;
    tests++; if (data_if.data_ok !== 1'b1) begin fails++; $display("FAIL prio_resp_d got=%0b exp=1", data_if.data_ok); end
    tests++; if (inst_if.data_ok !== 1'b0) begin fails++; $display("FAIL prio_resp_d_i got=%0b exp=0", inst_if.data_ok); end
    @(negedge clk);
    mem_if.rdata = 32'h22222222;
    #1;
    tests++; if (inst_if.data_ok !== 1'b1) begin fails++; $display("FAIL prio_resp_i got=%0b exp=1", inst_if.data_ok); end
    tests++; if (data_if.data_ok !== 1'b0) begin fails++; $display("FAIL prio_resp_i_d got=%0b exp=0", data_if.data_ok); end
    @(negedge clk);
    mem_if.data_ok = 0;
    #1;
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL prio_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_lock();
    apply_reset();
    data_if.req = 1; data_if.addr = 32'h80001000; inst_if.addr = 32'h1c000200;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) inst_if.req = 1;
      mem_if.addr_ok = (c == 3);
      #1;
      tests++; if (mem_if.addr !== 32'h80001000) begin fails++; $display("FAIL lock_addr c%0d got=%h exp=80001000", c, mem_if.addr); end
      tests++; if (inst_if.addr_ok !== 1'b0) begin fails++; $display("FAIL lock_iaok c%0d got=%0b exp=0", c, inst_if.addr_ok); end
      tests++; if (data_if.addr_ok !== (c == 3)) begin fails++; $display("FAIL lock_daok c%0d got=%0b exp=%0b", c, data_if.addr_ok, (c == 3)); end
      @(negedge clk);
    end
    data_if.req = 0;
    #1;
    tests++; if (inst_if.addr_ok !== 1'b1) begin fails++; $display("FAIL lock_after_iaok got=%0b exp=1", inst_if.addr_ok); end
    @(negedge clk);
    inst_if.req = 0; mem_if.addr_ok = 0;
    #1;
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL lock_out got=%0d exp=2", outstanding); end
  endtask

  task automatic test_full();
    apply_reset();
    inst_if.req = 1; inst_if.addr = 32'h1c000300; mem_if.addr_ok = 1;
    repeat (4) @(negedge clk);
    #1;
    tests++; if (outstanding !== 3'd4) begin fails++; $display("FAIL full_out got=%0d exp=4", outstanding); end
    tests++; if (mem_if.req !== 1'b0) begin fails++; $display("FAIL full_req got=%0b exp=0", mem_if.req); end
    tests++; if (inst_if.addr_ok !== 1'b0) begin fails++; $display("FAIL full_iaok got=%0b exp=0", inst_if.addr_ok); end
    @(negedge clk);
    mem_if.data_ok = 1;
    #1;
    tests++; if (mem_if.req !== 1'b0) begin fails++; $display("FAIL full_pop_req got=%0b exp=0", mem_if.req); end
    tests++; if (inst_if.addr_ok !== 1'b0) begin fails++; $display("FAIL full_pop_iaok got=%0b exp=0", inst_if.addr_ok); end
    tests++; if (inst_if.data_ok !== 1'b1) begin fails++; $display("FAIL full_pop_idok got=%0b exp=1", inst_if.data_ok); end
    @(negedge clk);
    mem_if.data_ok = 0;
    #1;
    tests++; if (outstanding !== 3'd3) begin fails++; $display("FAIL full_next_out got=%0d exp=3", outstanding); end
    tests++; if (inst_if.addr_ok !== 1'b1) begin fails++; $display("FAIL full_next_iaok got=%0b exp=1", inst_if.addr_ok); end
    @(negedge clk);
    inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1;
    repeat (4) @(negedge clk);
    mem_if.data_ok = 0;
    #1;
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL full_drain got=%0d exp=0", outstanding); end
    tests++; if (err_unexpected !== 1'b0) begin fails++; $display("FAIL full_err got=%0b exp=0", err_unexpected); end
  endtask

  task automatic test_starve();
    bit q[$];
    bit exp_g, head;
    apply_reset();
    inst_if.req = 1; inst_if.addr = 32'h1c000400;
    data_if.req = 1; data_if.addr = 32'h80002000; mem_if.addr_ok = 1;
    for (int k = 0; k < 45; k++) begin
      mem_if.data_ok = (q.size() > 0);
      mem_if.rdata   = 32'(k);
      #1;
      exp_g = ((k % 9) == 8) ? MASTER_INST : MASTER_DATA;
      tests++; if (inst_if.addr_ok !== (exp_g == MASTER_INST)) begin fails++; $display("FAIL starve_iaok k%0d got=%0b exp=%0b", k, inst_if.addr_ok, (exp_g == MASTER_INST)); end
      tests++; if (data_if.addr_ok !== (exp_g == MASTER_DATA)) begin fails++; $display("FAIL starve_daok k%0d got=%0b exp=%0b", k, data_if.addr_ok, (exp_g == MASTER_DATA)); end
      if (q.size() > 0) begin
        head = q.pop_front();
        tests++; if (inst_if.data_ok !== (head == MASTER_INST)) begin fails++; $display("FAIL starve_idok k%0d got=%0b exp=%0b", k, inst_if.data_ok, (head == MASTER_INST)); end
        tests++; if (data_if.data_ok !== (head == MASTER_DATA)) begin fails++; $display("FAIL starve_ddok k%0d got=%0b exp=%0b", k, data_if.data_ok, (head == MASTER_DATA)); end
      end
      q.push_back(exp_g);
      @(negedge clk);
    end
    inst_if.req = 0; data_if.req = 0; mem_if.addr_ok = 0;
    while (q.size() > 0) begin
      mem_if.data_ok = 1;
      #1;
      head = q.pop_front();
      tests++; if (data_if.data_ok !== (head == MASTER_DATA)) begin fails++; $display("FAIL starve_drain_ddok got=%0b exp=%0b", data_if.data_ok, (head == MASTER_DATA)); end
      @(negedge clk);
    end
    mem_if.data_ok = 0;
    #1;
    tests++; if (err_unexpected !== 1'b0) begin fails++; $display("FAIL starve_err got=%0b exp=0", err_unexpected); end
  endtask

  task automatic test_unexpected();
    apply_reset();
    mem_if.data_ok = 1;
    #1;
    tests++; if (inst_if.data_ok !== 1'b0) begin fails++; $display("FAIL unexp_idok got=%0b exp=0", inst_if.data_ok); end
    tests++; if (data_if.data_ok !== 1'b0) begin fails++; $display("FAIL unexp_ddok got=%0b exp=0", data_if.data_ok); end
    @(negedge clk);
    mem_if.data_ok = 0;
    #1;
    tests++; if (err_unexpected !== 1'b1) begin fails++; $display("FAIL unexp_err got=%0b exp=1", err_unexpected); end
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL unexp_out got=%0d exp=0", outstanding); end
    repeat (3) @(negedge clk);
    #1;
    tests++; if (err_unexpected !== 1'b1) begin fails++; $display("FAIL unexp_sticky got=%0b exp=1", err_unexpected); end
    apply_reset();
    #1;
    tests++; if (err_unexpected !== 1'b0) begin fails++; $display("FAIL unexp_clr got=%0b exp=0", err_unexpected); end
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL unexp_clr_out got=%0d exp=0", outstanding); end
    // A request in flight across a reset is forgotten.
    inst_if.req = 1; mem_if.addr_ok = 1;
    @(negedge clk);
    apply_reset();
    mem_if.data_ok = 1;
    #1;
    tests++; if (inst_if.data_ok !== 1'b0) begin fails++; $display("FAIL late_idok got=%0b exp=0", inst_if.data_ok); end
    @(negedge clk);
    mem_if.data_ok = 0;
    #1;
    tests++; if (err_unexpected !== 1'b1) begin fails++; $display("FAIL late_err got=%0b exp=1", err_unexpected); end
  endtask

  task automatic test_random();
    bit        q[$];
    int        lock_m, starve, g;
    bit        i_pend, d_pend, full, e_req, e_iaok, e_daok, e_idok, e_ddok;
    sram_req_t e_pl, got_pl;
    apply_reset();
    lock_m = -1; starve = 0; i_pend = 0; d_pend = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!i_pend && ($urandom_range(0, 3) == 0)) begin
        i_pend = 1;
        inst_if.wr = 1'($urandom_range(0, 1)); inst_if.size = 2'($urandom_range(0, 2));
        inst_if.addr = $urandom; inst_if.wstrb = 4'($urandom); inst_if.wdata = $urandom;
      end
      if (!d_pend && ($urandom_range(0, 7) != 0)) begin
        d_pend = 1;
        data_if.wr = 1'($urandom_range(0, 1)); data_if.size = 2'($urandom_range(0, 2));
        data_if.addr = $urandom; data_if.wstrb = 4'($urandom); data_if.wdata = $urandom;
      end
      inst_if.req = i_pend;
      data_if.req = d_pend;
      mem_if.addr_ok = ($urandom_range(0, 3) != 0);
      mem_if.data_ok = (q.size() > 0) && ($urandom_range(0, 7) < 5);
      mem_if.rdata   = $urandom;
      #1;
      if (lock_m >= 0) g = lock_m;
      else if (d_pend && !(i_pend && starve == SMAX)) g = 1;
      else if (i_pend) g = 0;
      else g = -1;
      full   = (q.size() == MAXO);
      e_req  = (g == 0 && i_pend || g == 1 && d_pend) && !full;
      e_pl   = '0;
      if (g == 0) e_pl = {inst_if.wr, inst_if.size, inst_if.addr, inst_if.wstrb, inst_if.wdata};
      if (g == 1) e_pl = {data_if.wr, data_if.size, data_if.addr, data_if.wstrb, data_if.wdata};
      e_iaok = e_req && mem_if.addr_ok && g == 0;
      e_daok = e_req && mem_if.addr_ok && g == 1;
      e_idok = mem_if.data_ok && q.size() > 0 && q[0] == 1'b0;
      e_ddok = mem_if.data_ok && q.size() > 0 && q[0] == 1'b1;
      got_pl = {mem_if.wr, mem_if.size, mem_if.addr, mem_if.wstrb, mem_if.wdata};
      tests++; if (mem_if.req !== e_req) begin fails++; $display("FAIL rnd_req k%0d got=%0b exp=%0b", k, mem_if.req, e_req); end
      tests++; if (got_pl !== e_pl) begin fails++; $display("FAIL rnd_payload k%0d got=%h exp=%h", k, got_pl, e_pl); end
      tests++; if (inst_if.addr_ok !== e_iaok) begin fails++; $display("FAIL rnd_iaok k%0d got=%0b exp=%0b", k, inst_if.addr_ok, e_iaok); end
      tests++; if (data_if.addr_ok !== e_daok) begin fails++; $display("FAIL rnd_daok k%0d got=%0b exp=%0b", k, data_if.addr_ok, e_daok); end
      tests++; if (inst_if.data_ok !== e_idok) begin fails++; $display("FAIL rnd_idok k%0d got=%0b exp=%0b", k, inst_if.data_ok, e_idok); end
      tests++; if (data_if.data_ok !== e_ddok) begin fails++; $display("FAIL rnd_ddok k%0d got=%0b exp=%0b", k, data_if.data_ok, e_ddok); end
      tests++; if (data_if.rdata !== mem_if.rdata) begin fails++; $display("FAIL rnd_rdata k%0d got=%h exp=%h", k, data_if.rdata, mem_if.rdata); end
      tests++; if (outstanding !== 3'(q.size())) begin fails++; $display("FAIL rnd_out k%0d got=%0d exp=%0d", k, outstanding, q.size()); end
      tests++; if (err_unexpected !== 1'b0) begin fails++; $display("FAIL rnd_err k%0d got=%0b exp=0", k, err_unexpected); end
      if (mem_if.data_ok && q.size() > 0) void'(q.pop_front());
      if (e_req && mem_if.addr_ok) begin
        q.push_back(g == 1);
        lock_m = -1;
      end else if (e_req) begin
        lock_m = g;
      end
      if (!i_pend) starve = 0;
      else if (e_iaok) starve = 0;
      else if (e_daok && starve < SMAX) starve++;
      if (e_iaok) i_pend = 0;
      if (e_daok) d_pend = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    resetn = 1;
    idle_inputs();
    test_reset();
    test_inst_only();
    test_priority();
    test_lock();
    test_full();
    test_starve();
    test_unexpected();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
